// File: rtl/note_synth.sv
// note_synth: note-command tone generator (phase accumulator, quarter-wave sine LUT, 2-stage output pipe).
// Define SYNTH_DECAY_EN to compile in the 8-bit decaying amplitude envelope (DECAY_SHIFT parameter).
module note_synth #(
  parameter int unsigned SAMPLE_WIDTH = 16,
  parameter int unsigned PHASE_WIDTH  = 24,
  parameter int unsigned DUR_WIDTH    = 16,
  parameter logic [PHASE_WIDTH-1:0] INC_1 = 24'h010000,
  parameter logic [PHASE_WIDTH-1:0] INC_2 = 24'h014000,
  parameter logic [PHASE_WIDTH-1:0] INC_3 = 24'h018000,
  parameter logic [PHASE_WIDTH-1:0] INC_4 = 24'h01C000
`ifdef SYNTH_DECAY_EN
  , parameter int unsigned DECAY_SHIFT = 4
`endif
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           advance,
  input  logic                           note_valid,
  input  logic [2:0]                     note_code,
  input  logic [DUR_WIDTH-1:0]           note_dur,
  output logic                           note_ready,
  output logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic                           sample_valid,
  output logic                           busy,
  output logic [2:0]                     cur_note
);

  typedef enum logic {S_IDLE, S_PLAY} state_t;

  // First quadrant (entries 0..64) of round(32767*sin(2*pi*k/256)); other quadrants by symmetry.
  localparam logic [15:0] QTAB [65] = '{
    16'd0,     16'd804,   16'd1608,  16'd2410,  16'd3212,  16'd4011,  16'd4808,  16'd5602,
    16'd6393,  16'd7179,  16'd7962,  16'd8739,  16'd9512,  16'd10278, 16'd11039, 16'd11793,
    16'd12539, 16'd13279, 16'd14010, 16'd14732, 16'd15446, 16'd16151, 16'd16846, 16'd17530,
    16'd18204, 16'd18868, 16'd19519, 16'd20159, 16'd20787, 16'd21403, 16'd22005, 16'd22594,
    16'd23170, 16'd23731, 16'd24279, 16'd24811, 16'd25329, 16'd25832, 16'd26319, 16'd26790,
    16'd27245, 16'd27683, 16'd28105, 16'd28510, 16'd28898, 16'd29268, 16'd29621, 16'd29956,
    16'd30273, 16'd30571, 16'd30852, 16'd31113, 16'd31356, 16'd31580, 16'd31785, 16'd31971,
    16'd32137, 16'd32285, 16'd32412, 16'd32521, 16'd32609, 16'd32678, 16'd32728, 16'd32757,
    16'd32767
  };

  state_t                          r_state, w_next;
  logic                            w_accept, w_last, w_play_adv;
  logic [2:0]                      r_cur_note;
  logic [DUR_WIDTH-1:0]            r_dur;
  logic [PHASE_WIDTH-1:0]          r_phase, w_inc;
  logic [7:0]                      w_idx;
  logic [6:0]                      w_qidx;
  logic signed [15:0]              w_lut16;
  logic signed [SAMPLE_WIDTH-1:0]  r_s1_lut, w_scaled, r_sample;
  logic                            r_s1_valid, r_s1_silent, r_valid;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_last     = 1'b0;
    w_play_adv = 1'b0;
    note_ready = 1'b0;
    busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        note_ready = 1'b1;
        if (note_valid) begin
          w_accept = 1'b1;
          w_next   = S_PLAY;
        end
      end
      S_PLAY: begin
        busy = 1'b1;
        if (advance) begin
          w_play_adv = 1'b1;
          if (r_dur <= DUR_WIDTH'(1)) begin
            w_last = 1'b1;
            w_next = S_IDLE;
          end
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    case (r_cur_note)
      3'd1:    w_inc = INC_1;
      3'd2:    w_inc = INC_2;
      3'd3:    w_inc = INC_3;
      3'd4:    w_inc = INC_4;
      default: w_inc = '0;
    endcase
  end

  // Bit 6 of the index mirrors within the half-wave, bit 7 negates.
  always_comb begin
    w_idx   = r_phase[PHASE_WIDTH-1 -: 8];
    w_qidx  = w_idx[6] ? (7'd64 - {1'b0, w_idx[5:0]}) : {1'b0, w_idx[5:0]};
    w_lut16 = w_idx[7] ? -$signed(QTAB[w_qidx]) : $signed(QTAB[w_qidx]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur_note  <= '0;
      r_dur       <= '0;
      r_phase     <= '0;
      r_s1_lut    <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_silent <= 1'b1;
      r_sample    <= '0;
      r_valid     <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cur_note <= (note_code <= 3'd4) ? note_code : 3'd0;
        r_dur      <= (note_dur == '0) ? DUR_WIDTH'(1) : note_dur;
        r_phase    <= '0;
      end else if (w_play_adv) begin
        r_phase <= r_phase + w_inc;
        r_dur   <= r_dur - DUR_WIDTH'(1);
        if (w_last) r_cur_note <= '0;
      end
      // Idle advances (including one coincident with an accept) emit a forced-zero sample.
      r_s1_valid  <= advance;
      r_s1_silent <= !w_play_adv || (r_cur_note == 3'd0);
      r_s1_lut    <= SAMPLE_WIDTH'(w_lut16);
      r_sample    <= r_s1_silent ? '0 : w_scaled;
      r_valid     <= r_s1_valid;
    end
  end

`ifdef SYNTH_DECAY_EN
  localparam logic [DECAY_SHIFT:0] DCNT_TOP = (DECAY_SHIFT+1)'((2 ** DECAY_SHIFT) - 1);

  logic [7:0]                     r_amp, r_s1_amp;
  logic [DECAY_SHIFT:0]           r_dcnt;
  logic signed [SAMPLE_WIDTH+8:0] w_prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_amp    <= '0;
      r_s1_amp <= '0;
      r_dcnt   <= '0;
    end else begin
      if (w_accept) begin
        r_amp  <= 8'd255;
        r_dcnt <= '0;
      end else if (w_play_adv) begin
        if (r_dcnt == DCNT_TOP) begin
          r_dcnt <= '0;
          if (r_amp != '0) r_amp <= r_amp - 8'd1;
        end else begin
          r_dcnt <= r_dcnt + (DECAY_SHIFT+1)'(1);
        end
      end
      r_s1_amp <= r_amp;
    end
  end

  assign w_prod   = r_s1_lut * $signed({1'b0, r_s1_amp});
  assign w_scaled = SAMPLE_WIDTH'(w_prod >>> 8);
`else
  assign w_scaled = r_s1_lut;
`endif

  assign sample       = r_sample;
  assign sample_valid = r_valid;
  assign cur_note     = r_cur_note;

endmodule

// File: tb/tb_note_synth.sv
// Bench for note_synth: four instances differing in INC_1, checked every cycle against a sine/real-math model.
module tb_note_synth;
  localparam int NI = 4;
  localparam logic [23:0] INC1_TAB [NI] = '{24'h010000, 24'h800000, 24'h400000, 24'h200000};
`ifdef SYNTH_DECAY_EN
  localparam int TB_DS = 0;
`endif

  logic        clk = 1'b0, rst_n = 1'b0, advance = 1'b0, note_valid = 1'b0;
  logic [2:0]  note_code = '0;
  logic [15:0] note_dur = '0;

  logic signed [15:0] s_smp [NI];
  logic               s_v [NI], s_rdy [NI], s_busy [NI];
  logic [2:0]         s_cur [NI];

  int n_tests = 0, n_fail = 0;
  int cap [NI][16];
  int ncap [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    note_synth #(
      .INC_1(INC1_TAB[g])
`ifdef SYNTH_DECAY_EN
      , .DECAY_SHIFT(TB_DS)
`endif
    ) u_dut (
      .clk(clk), .reset(rst_n), .advance(advance), .note_valid(note_valid),
      .note_code(note_code), .note_dur(note_dur), .note_ready(s_rdy[g]),
      .sample(s_smp[g]), .sample_valid(s_v[g]), .busy(s_busy[g]), .cur_note(s_cur[g])
    );
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Reference: rounded 32767*sin, scaled by the envelope amplitude of sample n.
  function automatic int sine_ref(input int k);
    real r;
    r = 32767.0 * $sin(2.0 * 3.14159265358979323846 * k / 256.0);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  function automatic int sample_ref(input int k, input int n);
    int amp;
`ifdef SYNTH_DECAY_EN
    amp = 255 - (n >> TB_DS);
    if (amp < 0) amp = 0;
`else
    amp = (n < 0) ? 0 : 256;
`endif
    return (sine_ref(k) * amp) >>> 8;
  endfunction

  function automatic int inc_ref(input int g, input int code);
    case (code)
      1:       return int'(INC1_TAB[g]);
      2:       return 'h014000;
      3:       return 'h018000;
      4:       return 'h01C000;
      default: return 0;
    endcase
  endfunction

  bit m_play;
  int m_code, m_left, m_n;
  int m_ph [NI];
  bit p_v [2];
  int p_s [2][NI];
  bit e_v;
  int e_s [NI];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_play = 0; m_code = 0; m_left = 0; m_n = 0;
      for (int g = 0; g < NI; g++) begin m_ph[g] = 0; p_s[0][g] = 0; p_s[1][g] = 0; end
      p_v[0] = 0; p_v[1] = 0;
    end else begin
      e_v = advance;
      for (int g = 0; g < NI; g++) e_s[g] = 0;
      if (!m_play) begin
        if (note_valid) begin
          m_play = 1;
          m_code = (note_code <= 3'd4) ? int'(note_code) : 0;
          m_left = (note_dur == 0) ? 1 : int'(note_dur);
          m_n    = 0;
          for (int g = 0; g < NI; g++) m_ph[g] = 0;
        end
      end else if (advance) begin
        for (int g = 0; g < NI; g++) begin
          if (m_code != 0) e_s[g] = sample_ref(m_ph[g] >> 16, m_n);
          m_ph[g] = (m_ph[g] + inc_ref(g, m_code)) % (1 << 24);
        end
        m_n++;
        m_left--;
        if (m_left == 0) m_play = 0;
      end
      p_v[1] = p_v[0]; p_s[1] = p_s[0];
      p_v[0] = e_v;    p_s[0] = e_s;
    end
  end

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      chk($sformatf("valid[%0d]", g), int'(s_v[g]), int'(p_v[1]));
      if (p_v[1]) chk($sformatf("sample[%0d]", g), int'(s_smp[g]), p_s[1][g]);
      chk($sformatf("ready[%0d]", g), int'(s_rdy[g]), int'(!m_play));
      chk($sformatf("busy[%0d]", g), int'(s_busy[g]), int'(m_play));
      chk($sformatf("cur_note[%0d]", g), int'(s_cur[g]), m_play ? m_code : 0);
      if (s_v[g] === 1'b1 && ncap[g] < 16) begin
        cap[g][ncap[g]] = int'(s_smp[g]);
        ncap[g]++;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    for (int g = 0; g < NI; g++) ncap[g] = 0;
  endtask

  task automatic pulse_adv(input int gap);
    advance = 1'b1;
    step();
    advance = 1'b0;
    repeat (gap - 1) step();
  endtask

  task automatic play(input logic [2:0] c, input logic [15:0] d, input int gap, output int nadv);
    note_valid = 1'b1; note_code = c; note_dur = d;
    step();
    note_valid = 1'b0;
    nadv = 0;
    while (s_busy[0] && nadv < 200) begin
      pulse_adv(gap);
      nadv++;
    end
    repeat (3) step();
  endtask

  task automatic chk_cap(input string nm, input int g, input int n, input int e [6]);
    chk({nm, "_count"}, ncap[g], n);
    for (int i = 0; i < n && i < ncap[g]; i++) chk($sformatf("%s_%0d", nm, i), cap[g][i], e[i]);
  endtask

  int nadv, k;

  initial begin
    for (int g = 0; g < NI; g++) ncap[g] = 0;
    chk("model_lut1", sine_ref(1), 804);
    chk("model_lut3", sine_ref(3), 2410);
    chk("model_lut64", sine_ref(64), 32767);
    chk("model_lut192", sine_ref(192), -32767);

    // Reset state, then idle advances emit zero samples.
    step(); advance = 1'b1; step(); advance = 1'b0; step();
    rst_n = 1'b1;
    step();
    chk("rst_ready", int'(s_rdy[0]), 1);
    chk("rst_sample", int'(s_smp[0]), 0);
    chk("rst_busy", int'(s_busy[0]), 0);
    chk("rst_valid", int'(s_v[0]), 0);
    clr();
    repeat (3) pulse_adv(2);
    repeat (3) step();
    chk_cap("idle_zero", 0, 3, '{0, 0, 0, 0, 0, 0});

    // Note 1, dur 4, advance every 4 cycles.
    clr();
    play(3'd1, 16'd4, 4, nadv);
    chk("n1_advances", nadv, 4);
`ifdef SYNTH_DECAY_EN
    chk_cap("n1_u0", 0, 4, '{0, 797, 1589, 2372, 0, 0});
    chk_cap("n1_u2", 2, 4, '{0, 32511, 0, -32256, 0, 0});
    chk_cap("n1_u3", 3, 4, '{0, 22988, 32383, 22807, 0, 0});
`else
    chk_cap("n1_u0", 0, 4, '{0, 804, 1608, 2410, 0, 0});
    chk_cap("n1_u2", 2, 4, '{0, 32767, 0, -32767, 0, 0});
    chk_cap("n1_u3", 3, 4, '{0, 23170, 32767, 23170, 0, 0});
`endif
    chk_cap("n1_u1", 1, 4, '{0, 0, 0, 0, 0, 0});

    // dur 0 behaves as 1; out-of-range and silent codes.
    clr();
    play(3'd3, 16'd0, 1, nadv);
    chk("dur0_advances", nadv, 1);
    chk_cap("dur0_u0", 0, 1, '{0, 0, 0, 0, 0, 0});
    clr();
    play(3'd6, 16'd3, 2, nadv);
    chk("code6_advances", nadv, 3);
    chk_cap("code6_u3", 3, 3, '{0, 0, 0, 0, 0, 0});
    clr();
    play(3'd0, 16'd3, 1, nadv);
    chk("code0_advances", nadv, 3);
    chk_cap("code0_u2", 2, 3, '{0, 0, 0, 0, 0, 0});

    // Full-throughput and mixed-rate notes, checked by the model.
    play(3'd4, 16'd20, 1, nadv);
    chk("n4_advances", nadv, 20);
    play(3'd2, 16'd5, 3, nadv);
    chk("n2_advances", nadv, 5);

    // Command held during PLAY; accepted on the first idle cycle together with an advance.
    clr();
    note_valid = 1'b1; note_code = 3'd1; note_dur = 16'd3;
    step();
    note_code = 3'd2; note_dur = 16'd2; advance = 1'b1;
    k = 0;
    while (!s_rdy[0] && k < 50) begin step(); k++; end
    chk("hs_wait", k, 3);
    step();
    note_valid = 1'b0;
    step(); step();
    advance = 1'b0;
    repeat (3) step();
`ifdef SYNTH_DECAY_EN
    chk_cap("hs_u0", 0, 6, '{0, 797, 1589, 0, 0, 797});
`else
    chk_cap("hs_u0", 0, 6, '{0, 804, 1608, 0, 0, 804});
`endif

    // Reset mid-note with samples in flight.
    note_valid = 1'b1; note_code = 3'd1; note_dur = 16'd10;
    step();
    note_valid = 1'b0;
    pulse_adv(2); pulse_adv(2);
    advance = 1'b1; step(); step(); advance = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("mrst_sample", int'(s_smp[0]), 0);
    chk("mrst_valid", int'(s_v[0]), 0);
    chk("mrst_busy", int'(s_busy[0]), 0);
    chk("mrst_ready", int'(s_rdy[0]), 1);
    chk("mrst_cur", int'(s_cur[0]), 0);
    repeat (3) step();
    rst_n = 1'b1;
    clr();
    repeat (3) step();
    chk("mrst_no_partial", ncap[0], 0);
    pulse_adv(1);
    repeat (3) step();
    chk_cap("mrst_after", 0, 1, '{0, 0, 0, 0, 0, 0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/note_synth.md
# note_synth

Tone generator for the xylophone signal path: it produces the audio sample stream that the bin detector decodes. It accepts note commands (code 0 = silence, 1-4 = the four detector bins) with a duration in samples. For each sample strobe it emits one signed sine sample at the note's frequency, using a phase accumulator and a sine lookup table. It drives the codec/test path in place of, or alongside, live audio.

## Interface
- SAMPLE_WIDTH, 16, output sample width (signed, two's complement)
- PHASE_WIDTH, 24, phase accumulator width
- DUR_WIDTH, 16, note duration counter width
- INC_1 / INC_2 / INC_3 / INC_4, 24'h010000 / 24'h014000 / 24'h018000 / 24'h01C000, per-bin phase increment
- DECAY_SHIFT, 4, envelope step period is 2^DECAY_SHIFT samples (used only with decay compiled in)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- advance  in  1  sample strobe, one-cycle pulse per audio sample
- note_valid  in  1  note command valid
- note_code  in  3  0 silence, 1-4 bin, 5-7 treated as silence
- note_dur  in  DUR_WIDTH  note length in samples (0 treated as 1)
- note_ready  out  1  high only in IDLE
- sample  out  SAMPLE_WIDTH  signed output sample
- sample_valid  out  1  one-cycle pulse per emitted sample
- busy  out  1  high in PLAY
- cur_note  out  3  code currently playing (0 in IDLE)

## Operation
- State machine:
  - IDLE: note_ready=1. A command is accepted on note_valid && note_ready. On accept:
    - latch note_code into cur_note (codes 5-7 latched as 0);
    - load dur_cnt = max(note_dur,1);
    - clear phase to 0;
    - go to PLAY.
  - PLAY: on each advance, phase is used for lookup, then phase += INC[cur_note] (modulo 2^PHASE_WIDTH, wrap-around is intended) and dur_cnt decrements. When dur_cnt reaches 0 on an advance, go to IDLE at the next edge.
  - IDLE on advance: a zero sample is still emitted, so the stream stays continuous.
- Silence (cur_note=0): the increment is 0 and the output is forced to 0 for the full duration.
- Sine LUT: 256 entries indexed by phase[PHASE_WIDTH-1 -: 8]. Entry k = round((2^(SAMPLE_WIDTH-1)-1)·sin(2πk/256)).
- Pipeline, two stages:
  - stage 1 registers the LUT output, the silence flag and the envelope value;
  - stage 2 registers the final sample and sample_valid.
- Simultaneous events:
  - accept and advance in the same IDLE cycle: accept wins, and that advance emits a zero sample.
  - note_valid outside IDLE: ignored. The command is not queued, and the source must hold it until note_ready.
- Reset asserted mid-note: all state is cleared immediately. No partial sample appears after reset release.
- Reset values: sample=0, sample_valid=0, note_ready=1 (IDLE), busy=0, cur_note=0, phase=0, dur_cnt=0, pipeline registers 0.

## Timing
- advance high at cycle t: sample and sample_valid appear at t+2.
- Back-to-back advance (every cycle) is supported at full throughput.
- The first PLAY sample is LUT[0]. Exactly dur_cnt PLAY samples are emitted per note.
- note_ready rises the cycle after the final PLAY advance. The minimum gap between notes is 1 cycle plus the source's valid latency.
- busy and cur_note change on the same edge as the state.

## Configuration
- SYNTH_DECAY_EN defined:
  - An 8-bit amplitude register loads 255 on accept.
  - It decrements by 1 every 2^DECAY_SHIFT PLAY samples and saturates at 0.
  - Stage 2 outputs (LUT·amp)>>>8, arithmetic shift, with the product truncated back to SAMPLE_WIDTH.
- SYNTH_DECAY_EN undefined:
  - No amplitude register exists.
  - Stage 2 passes the LUT value unchanged.
  - Latency stays 2 cycles.

## Test plan
- Reset: hold reset=0 then release. Required: note_ready=1, sample=0, busy=0. Advance pulses give sample_valid with sample=0.
- Note 1, dur=4, decay off, advance every 4 cycles. Required samples 0, 804, 1608, 2410. busy drops after the 4th advance, then note_ready=1.
- Note 3, dur=0. Required: exactly one sample (0), then IDLE. Codes 6 and 0 with dur=3: three zero samples each, cur_note=0.
- Wrap-around: INC_1=24'h800000, dur=3. Required: phase indices 0, 128, 0, giving samples 0, 0, 0. Then INC_1=24'h400000 gives samples 0, 32767, 0, -32767.
- Handshake: note_valid held during PLAY. It is ignored until IDLE and accepted on the first IDLE cycle. An accept coincident with an advance emits a zero sample first.
- Reset mid-note at sample 2 of dur=10. Required: all outputs 0 immediately, and after release no sample_valid until the next advance, with sample=0. With SYNTH_DECAY_EN and DECAY_SHIFT=0: amplitudes 255, 254, … and a LUT[64] sample equals (32767·253)>>>8.
